// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Fetch stage. Owns the program counter, presents it to a
//               combinational instruction memory and captures each returned
//               word, tagged with its address, into a small prefetch FIFO
//               drained by decode over a valid/ready handshake. A redirect
//               flushes the FIFO and restarts fetch at a new, word-aligned
//               target.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_instr,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [XLEN-1:0]            instr,
    output logic [XLEN-1:0]            instr_pc,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);
    localparam logic [XLEN-1:0] C_STEP = XLEN'(4);

    // Prefetch storage: one address and one instruction word per entry.
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] pc_mem_d    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] instr_mem_d [DEPTH];

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]   count_q,    count_d;

    logic w_full;
    logic w_pop;
    logic w_push;

    // The two alignment bits of a redirect target are dropped by design.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Handshake and occupancy decode; a redirect suppresses both push and pop
    // so the head being accepted during a flush is discarded, not consumed.
    always_comb begin
        w_full = (count_q == C_DEPTH);
        w_pop  = instr_valid & instr_ready & ~redirect_valid;
        w_push = ~redirect_valid & (~w_full | w_pop);
    end

    // Next-state for PC, pointers, occupancy and the storage arrays.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (w_push) begin
                pc_mem_d[wr_ptr_q]    = fetch_pc_q;
                instr_mem_d[wr_ptr_q] = imem_instr;
                wr_ptr_d              = wr_ptr_q + AW'(1);
                fetch_pc_d            = fetch_pc_q + C_STEP;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + CW'(1);
            end else if (w_pop && !w_push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage needs no reset: contents are only observed when counted.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

    // Outputs come straight from registered state.
    always_comb begin
        imem_addr   = fetch_pc_q;
        instr_valid = (count_q != '0);
        instr       = instr_mem_q[rd_ptr_q];
        instr_pc    = pc_mem_q[rd_ptr_q];
        fifo_count  = count_q;
    end

endmodule
`default_nettype wire
